kronos_fetch_redirect: RTL and testbench

- Instruction-fetch front end and consumer of the branch decision made in execute by the branch comparator.
- Drives sequential PC fetches over a classic req/ack instruction bus and presents {pc, ir} to decode with valid/ready handshaking.
- Holds a 1-entry skid buffer for back-pressure.
- On a taken branch/jump, flushes buffered and in-flight fetches and restarts at the target.

---
 rtl/kronos_fetch_redirect.sv | 216 +++++++++++++++++++++
 tb/tb_kronos_fetch_redirect.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_fetch_redirect.sv
// kronos_fetch_redirect
//   Instruction-fetch front end. It issues sequential fetches on a req/ack
//   instruction bus and presents {pc, ir} to decode with a valid/ready
//   handshake. A 1-entry skid buffer absorbs decode back-pressure. A taken
//   branch from execute flushes the buffered words and any in-flight fetch,
//   then restarts fetching at the branch target.
//
//   Optional feature macro: KRONOS_FETCH_ALIGN_CHECK_EN
//     When it is defined, a branch to a non-word-aligned target raises
//     fetch_misalign and idles the fetch unit until an aligned branch arrives.
//     When it is undefined, the low two target bits are ignored.
//
//   Ports
//     clk, rst        core clock; asynchronous active-high reset
//     instr_addr/req  fetch address and request, held until instr_ack
//     instr_data/ack  fetched word and completion strobe
//     fetch_pc/ir/vld instruction presented to decode
//     fetch_rdy       decode accepts when fetch_vld & fetch_rdy
//     branch          one-cycle taken-branch/jump pulse from execute
//     branch_target   redirect PC, sampled while branch=1
//     fetch_misalign  misaligned-target flag (feature macro only)

module kronos_fetch_redirect #(
  parameter logic [31:0] BOOT_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  output logic        instr_req,
  input  logic [31:0] instr_data,
  input  logic        instr_ack,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_ir,
  output logic        fetch_vld,
  input  logic        fetch_rdy,
  input  logic        branch,
  input  logic [31:0] branch_target
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_FETCH,
    ST_STALL,
    ST_DISCARD,
    ST_IDLE
  } state_e;

  state_e      state_q,   state_d;
  logic        req_q,     req_d;
  logic [31:0] addr_q,    addr_d;
  logic        vld_q,     vld_d;
  logic [31:0] pc_q,      pc_d;
  logic [31:0] ir_q,      ir_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_ir_q, skid_ir_d;
  logic [31:0] target_q,  target_d;

  logic [31:0] tgt;
  logic        br_misaligned;
  logic        acked;

`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
  logic        misalign_q, misalign_d;

  assign tgt           = branch_target;
  assign br_misaligned = |branch_target[1:0];
`else
  assign tgt           = branch_target & ~32'h3;
  assign br_misaligned = 1'b0;
`endif

  assign acked = req_q & instr_ack;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    vld_d      = vld_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    skid_vld_d = skid_vld_q;
    skid_pc_d  = skid_pc_q;
    skid_ir_d  = skid_ir_q;
    target_d   = target_q;
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
    misalign_d = misalign_q;
`endif

    // Output drains whenever decode takes it and nothing replaces it below.
    if (vld_q && fetch_rdy) vld_d = 1'b0;

    if (state_q == ST_INIT) begin
      // Leaving reset: a branch here replaces the boot fetch entirely.
      state_d = ST_FETCH;
      req_d   = 1'b1;
      addr_d  = BOOT_ADDR;
      if (branch) begin
        target_d = tgt;
        addr_d   = tgt;
        if (br_misaligned) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
        misalign_d = br_misaligned;
`endif
      end
    end else if (branch) begin
      vld_d      = 1'b0;
      skid_vld_d = 1'b0;
      target_d   = tgt;
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
      misalign_d = br_misaligned;
`endif
      if (br_misaligned) begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end else if (req_q && !instr_ack) begin
        // Outstanding request must complete with address unchanged; its
        // data is thrown away. A repeat branch here just moves the target.
        state_d = ST_DISCARD;
      end else begin
        state_d = ST_FETCH;
        req_d   = 1'b1;
        addr_d  = tgt;
      end
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (acked) begin
            addr_d = addr_q + 32'd4;
            if (!vld_q || fetch_rdy) begin
              vld_d = 1'b1;
              pc_d  = addr_q;
              ir_d  = instr_data;
            end else begin
              // Skid is always empty in FETCH: it only fills on the way into
              // STALL and drains on the way out.
              skid_vld_d = 1'b1;
              skid_pc_d  = addr_q;
              skid_ir_d  = instr_data;
              req_d      = 1'b0;
              state_d    = ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (fetch_rdy) begin
            vld_d      = 1'b1;
            pc_d       = skid_pc_q;
            ir_d       = skid_ir_q;
            skid_vld_d = 1'b0;
            req_d      = 1'b1;
            state_d    = ST_FETCH;
          end
        end
        ST_DISCARD: begin
          if (acked) begin
            addr_d  = target_q;
            state_d = ST_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      req_q      <= 1'b0;
      addr_q     <= BOOT_ADDR;
      vld_q      <= 1'b0;
      pc_q       <= BOOT_ADDR;
      ir_q       <= NOP;
      skid_vld_q <= 1'b0;
      skid_pc_q  <= '0;
      skid_ir_q  <= '0;
      target_q   <= '0;
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      vld_q      <= vld_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      skid_vld_q <= skid_vld_d;
      skid_pc_q  <= skid_pc_d;
      skid_ir_q  <= skid_ir_d;
      target_q   <= target_d;
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign instr_addr = addr_q;
  assign instr_req  = req_q;
  assign fetch_pc   = pc_q;
  assign fetch_ir   = ir_q;
  assign fetch_vld  = vld_q;
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
  assign fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_kronos_fetch_redirect.sv
// tb_kronos_fetch_redirect
//   Directed bench for kronos_fetch_redirect with BOOT_ADDR=32'h100. A small
//   bus slave answers requests with data = addr ^ 32'hA5A5A5A5, either every
//   cycle or after a fixed delay. Inputs change on the falling edge, the slave
//   responds 1 time unit later, and outputs are checked on the falling edge.

module tb_kronos_fetch_redirect;

  localparam logic [31:0] K   = 32'hA5A5_A5A5;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic        instr_req;
  logic [31:0] instr_data;
  logic        instr_ack;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_ir;
  logic        fetch_vld;
  logic        fetch_rdy;
  logic        branch;
  logic [31:0] branch_target;
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int          n_total = 0;
  int          n_bad   = 0;
  int          ack_mode;       // 0 never, 1 every request cycle, 2 delayed
  int          dcnt;
  logic        saw_4000 = 1'b0;

  kronos_fetch_redirect #(.BOOT_ADDR(32'h100)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_addr    (instr_addr),
    .instr_req     (instr_req),
    .instr_data    (instr_data),
    .instr_ack     (instr_ack),
    .fetch_pc      (fetch_pc),
    .fetch_ir      (fetch_ir),
    .fetch_vld     (fetch_vld),
    .fetch_rdy     (fetch_rdy),
    .branch        (branch),
    .branch_target (branch_target)
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
    ,
    .fetch_misalign(fetch_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Bus slave: delayed mode acks on the 4th consecutive request cycle.
  initial begin
    instr_ack  = 1'b0;
    instr_data = '0;
    dcnt       = 0;
    forever begin
      @(negedge clk);
      #1;
      if (ack_mode == 2) begin
        if (instr_req) begin
          if (dcnt == 3) begin
            instr_ack = 1'b1;
            dcnt      = 0;
          end else begin
            instr_ack = 1'b0;
            dcnt++;
          end
        end else begin
          instr_ack = 1'b0;
        end
      end else begin
        instr_ack = (ack_mode == 1) && instr_req;
        dcnt      = 0;
      end
      instr_data = instr_addr ^ K;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (instr_req && instr_addr == 32'h4000) saw_4000 = 1'b1;
    end
  end

  initial begin
    rst           = 1'b1;
    fetch_rdy     = 1'b1;
    branch        = 1'b0;
    branch_target = '0;
    ack_mode      = 1;

    repeat (2) @(negedge clk);
    chk("rst_req",  {31'b0, instr_req}, 32'h0);
    chk("rst_addr", instr_addr, 32'h100);
    chk("rst_vld",  {31'b0, fetch_vld}, 32'h0);
    chk("rst_pc",   fetch_pc, 32'h100);
    chk("rst_ir",   fetch_ir, NOP);
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
    chk("rst_mis",  {31'b0, fetch_misalign}, 32'h0);
`endif
    rst = 1'b0;

    // Boot streaming
    @(negedge clk);
    chk("boot_req",  {31'b0, instr_req}, 32'h1);
    chk("boot_addr", instr_addr, 32'h100);
    chk("boot_vld",  {31'b0, fetch_vld}, 32'h0);
    @(negedge clk);
    chk("s0_vld", {31'b0, fetch_vld}, 32'h1);
    chk("s0_pc",  fetch_pc, 32'h100);
    chk("s0_ir",  fetch_ir, 32'h100 ^ K);
    @(negedge clk);
    chk("s1_pc",  fetch_pc, 32'h104);
    chk("s1_ir",  fetch_ir, 32'h104 ^ K);
    fetch_rdy = 1'b0;

    // Back-pressure: 0x104 in output, 0x108 in skid
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stl_req", {31'b0, instr_req}, 32'h0);
      chk("stl_pc",  fetch_pc, 32'h104);
      chk("stl_vld", {31'b0, fetch_vld}, 32'h1);
    end
    fetch_rdy = 1'b1;
    ack_mode  = 2;
    @(negedge clk);
    chk("unst_pc",   fetch_pc, 32'h108);
    chk("unst_ir",   fetch_ir, 32'h108 ^ K);
    chk("unst_vld",  {31'b0, fetch_vld}, 32'h1);
    chk("unst_req",  {31'b0, instr_req}, 32'h1);
    chk("unst_addr", instr_addr, 32'h10C);

    // Branch with outstanding request -> DISCARD
    branch        = 1'b1;
    branch_target = 32'h2000;
    @(negedge clk);
    branch = 1'b0;
    chk("dis_vld",  {31'b0, fetch_vld}, 32'h0);
    chk("dis_req",  {31'b0, instr_req}, 32'h1);
    chk("dis_addr", instr_addr, 32'h10C);
    @(negedge clk);
    chk("dis_addr1", instr_addr, 32'h10C);
    @(negedge clk);
    chk("dis_addr2", instr_addr, 32'h10C);
    chk("dis_vld2",  {31'b0, fetch_vld}, 32'h0);
    @(negedge clk);
    chk("redir_addr", instr_addr, 32'h2000);
    chk("redir_req",  {31'b0, instr_req}, 32'h1);
    chk("redir_vld",  {31'b0, fetch_vld}, 32'h0);
    ack_mode = 1;
    @(negedge clk);
    chk("b1_pc",  fetch_pc, 32'h2000);
    chk("b1_ir",  fetch_ir, 32'h2000 ^ K);
    chk("b1_vld", {31'b0, fetch_vld}, 32'h1);

    // Branch coincident with ack
    branch        = 1'b1;
    branch_target = 32'h3000;
    @(negedge clk);
    branch = 1'b0;
    chk("co_addr", instr_addr, 32'h3000);
    chk("co_req",  {31'b0, instr_req}, 32'h1);
    chk("co_vld",  {31'b0, fetch_vld}, 32'h0);
    @(negedge clk);
    chk("co_pc",   fetch_pc, 32'h3000);
    chk("co_vld1", {31'b0, fetch_vld}, 32'h1);

    // Two branches while DISCARD pending: last target wins
    ack_mode      = 2;
    branch        = 1'b1;
    branch_target = 32'h4000;
    @(negedge clk);
    branch_target = 32'h5000;
    chk("dd_vld", {31'b0, fetch_vld}, 32'h0);
    @(negedge clk);
    branch = 1'b0;
    chk("dd_addr",  instr_addr, 32'h3004);
    chk("dd_req",   {31'b0, instr_req}, 32'h1);
    @(negedge clk);
    chk("dd_addr1", instr_addr, 32'h3004);
    @(negedge clk);
    chk("dd_redir", instr_addr, 32'h5000);
    chk("dd_req1",  {31'b0, instr_req}, 32'h1);
    ack_mode = 1;
    @(negedge clk);
    chk("dd_pc",   fetch_pc, 32'h5000);
    chk("no_4000", {31'b0, saw_4000}, 32'h0);

    // Address wrap
    branch        = 1'b1;
    branch_target = 32'hFFFF_FFF8;
    @(negedge clk);
    branch = 1'b0;
    chk("wr_addr", instr_addr, 32'hFFFF_FFF8);
    chk("wr_vld",  {31'b0, fetch_vld}, 32'h0);
    @(negedge clk);
    chk("wr_pc0", fetch_pc, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wr_pc1", fetch_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wr_pc2", fetch_pc, 32'h0000_0000);
    chk("wr_ir2", fetch_ir, 32'h0000_0000 ^ K);
    chk("wr_nxt", instr_addr, 32'h0000_0004);

    // Misaligned target
    branch        = 1'b1;
    branch_target = 32'h2002;
    @(negedge clk);
    branch = 1'b0;
`ifdef KRONOS_FETCH_ALIGN_CHECK_EN
    chk("mis_flag", {31'b0, fetch_misalign}, 32'h1);
    chk("mis_req",  {31'b0, instr_req}, 32'h0);
    chk("mis_vld",  {31'b0, fetch_vld}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("mis_idle", {31'b0, instr_req}, 32'h0);
      chk("mis_hold", {31'b0, fetch_misalign}, 32'h1);
    end
    branch        = 1'b1;
    branch_target = 32'h2004;
    @(negedge clk);
    branch = 1'b0;
    chk("al_flag", {31'b0, fetch_misalign}, 32'h0);
    chk("al_req",  {31'b0, instr_req}, 32'h1);
    chk("al_addr", instr_addr, 32'h2004);
    @(negedge clk);
    chk("al_pc", fetch_pc, 32'h2004);
`else
    chk("lo_addr", instr_addr, 32'h2000);
    chk("lo_req",  {31'b0, instr_req}, 32'h1);
    chk("lo_vld",  {31'b0, fetch_vld}, 32'h0);
    @(negedge clk);
    chk("lo_pc", fetch_pc, 32'h2000);
`endif

    // Reset mid-stream
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_req",  {31'b0, instr_req}, 32'h0);
    chk("mr_addr", instr_addr, 32'h100);
    chk("mr_vld",  {31'b0, fetch_vld}, 32'h0);
    chk("mr_pc",   fetch_pc, 32'h100);
    chk("mr_ir",   fetch_ir, NOP);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_req1",  {31'b0, instr_req}, 32'h1);
    chk("mr_addr1", instr_addr, 32'h100);
    @(negedge clk);
    chk("mr_pc1", fetch_pc, 32'h100);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
